ps2_mouse_rx: RTL and testbench

Parametrised PS/2 mouse receiver running entirely in the system clk domain. It oversamples ps2_clk/ps2_data, assembles and checks 11-bit frames, and collects 3- or 4-byte (wheel) packets. It decodes buttons and signed motion, keeps a saturating cursor position, and flags direction. It replaces the ps2_clk-edge-driven packet capture and feeds the LED/cursor logic downstream.

---
 rtl/ps2_mouse_pkg.sv | 23 ++
 rtl/ps2_mouse_rx_if.sv | 31 +++
 rtl/ps2_frame_rx.sv | 115 +++++++++++
 rtl/ps2_mouse_rx.sv | 144 ++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: frame FSM states
// and the bit layout of the packet's first (status) byte.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam int FRAME_BITS = 11;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Decoded mouse packet bus: packet fields, cursor position, direction flags
// and error pulses, driven by the receiver and consumed by cursor/LED logic.
interface ps2_mouse_rx_if #(
    parameter int POS_W = 10
);
    logic               pkt_valid;
    logic [2:0]         buttons;
    logic signed [8:0]  dx;
    logic signed [8:0]  dy;
    logic signed [3:0]  dz;
    logic               x_ovf;
    logic               y_ovf;
    logic [POS_W-1:0]   x_pos;
    logic [POS_W-1:0]   y_pos;
    logic               dir_left;
    logic               dir_right;
    logic               dir_up;
    logic               dir_down;
    logic               frame_err;
    logic               timeout_err;

    modport master (
        output pkt_valid, buttons, dx, dy, dz, x_ovf, y_ovf, x_pos, y_pos,
               dir_left, dir_right, dir_up, dir_down, frame_err, timeout_err
    );

    modport slave (
        input  pkt_valid, buttons, dx, dy, dz, x_ovf, y_ovf, x_pos, y_pos,
               dir_left, dir_right, dir_up, dir_down, frame_err, timeout_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line front end: 2-FF synchronisers, ps2_clk glitch filter, falling-edge
// detect and the 11-bit frame FSM with odd-parity and stop-bit checks.
module ps2_frame_rx
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       abort,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       fe,
    output logic       busy
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             clk_s1, clk_s2, dat_s1, dat_s2;
    logic             clk_filt, dat_fe, fall;
    logic [CNT_W-1:0] flt_cnt;
    frame_state_t     state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
    assign fall = clk_filt && !clk_s2 && (flt_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fe       <= 1'b0;
            dat_fe   <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == CNT_LAST) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
            fe     <= fall && enable;
            dat_fe <= dat_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!enable || abort) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else if (fe) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!dat_fe) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        if (^{shreg, dat_fe}) begin
                            state <= ST_STOP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_STOP: begin
                        if (dat_fe) byte_valid <= 1'b1;
                        else        frame_err  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enable && !abort && fe && state == ST_DATA)
            shreg <= {dat_fe, shreg[7:1]};
    end

    assign rx_byte = shreg;
    assign busy    = (state != ST_IDLE);

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: packet assembly with sync-bit resync, inactivity
// watchdog, field decode and a saturating cursor position.
module ps2_mouse_rx
    import ps2_mouse_pkg::*;
#(
    parameter int PKT_BYTES      = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int POS_W          = 10,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_mouse_rx_if.master mouse
);

    localparam int SW   = POS_W + 2;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]           IDX_LAST = 2'(PKT_BYTES - 1);
    localparam logic signed [SW-1:0] X_HI     = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_HI     = SW'(Y_MAX);

    logic            byte_valid, frame_err, fe, busy, abort;
    logic [7:0]      rx_byte;
    logic [1:0]      idx;
    logic [WD_W-1:0] wd;
    logic            vld_p0;
    logic [7:0]      bytes_p0 [4];
    logic [7:0]      b0;
    logic signed [8:0]    dx_p0, dy_p0;
    logic signed [3:0]    dz_p0;
    logic signed [SW-1:0] x_sum, y_dif;

    function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] v,
                                               input logic signed [SW-1:0] hi);
        if (v < 0)       return '0;
        else if (v > hi) return hi[POS_W-1:0];
        else             return v[POS_W-1:0];
    endfunction

    ps2_frame_rx #(.FILTER_LEN(FILTER_LEN)) u_frame (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .abort      (abort),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .fe         (fe),
        .busy       (busy)
    );

    assign mouse.frame_err = frame_err;

    // An edge in the same cycle as terminal count keeps the transfer alive.
    assign abort = enable && !fe && (busy || idx != 2'd0) && (wd == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx               <= '0;
            wd                <= '0;
            vld_p0            <= 1'b0;
            mouse.timeout_err <= 1'b0;
        end else begin
            vld_p0            <= 1'b0;
            mouse.timeout_err <= abort;
            if (!enable) begin
                idx <= '0;
                wd  <= '0;
            end else begin
                if (fe || abort || !(busy || idx != 2'd0)) wd <= '0;
                else                                        wd <= wd + 1'b1;
                if (abort || frame_err) begin
                    idx <= '0;
                end else if (byte_valid && (idx != 2'd0 || rx_byte[SYNC])) begin
                    if (idx == IDX_LAST) begin
                        idx    <= '0;
                        vld_p0 <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid && (idx != 2'd0 || rx_byte[SYNC]))
            bytes_p0[idx] <= rx_byte;
    end

    // Stage p0 -> p1: decode the assembled bytes and move the cursor.
    assign b0    = bytes_p0[0];
    assign dx_p0 = {b0[XS], bytes_p0[1]};
    assign dy_p0 = {b0[YS], bytes_p0[2]};
    assign dz_p0 = (PKT_BYTES == 4) ? bytes_p0[3][3:0] : 4'sd0;
    assign x_sum = $signed({2'b00, mouse.x_pos}) + {{(SW-9){dx_p0[8]}}, dx_p0};
    assign y_dif = $signed({2'b00, mouse.y_pos}) - {{(SW-9){dy_p0[8]}}, dy_p0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mouse.pkt_valid <= 1'b0;
            mouse.buttons   <= '0;
            mouse.dx        <= '0;
            mouse.dy        <= '0;
            mouse.dz        <= '0;
            mouse.x_ovf     <= 1'b0;
            mouse.y_ovf     <= 1'b0;
            mouse.x_pos     <= POS_W'(X_INIT);
            mouse.y_pos     <= POS_W'(Y_INIT);
            mouse.dir_left  <= 1'b0;
            mouse.dir_right <= 1'b0;
            mouse.dir_up    <= 1'b0;
            mouse.dir_down  <= 1'b0;
        end else begin
            mouse.pkt_valid <= 1'b0;
            if (vld_p0 && enable) begin
                mouse.pkt_valid <= 1'b1;
                mouse.buttons   <= {b0[BTN_M], b0[BTN_R], b0[BTN_L]};
                mouse.dx        <= dx_p0;
                mouse.dy        <= dy_p0;
                mouse.dz        <= dz_p0;
                mouse.x_ovf     <= b0[XO];
                mouse.y_ovf     <= b0[YO];
                if (!b0[XO]) mouse.x_pos <= clamp(x_sum, X_HI);
                if (!b0[YO]) mouse.y_pos <= clamp(y_dif, Y_HI);
                mouse.dir_right <= (dx_p0 > 0);
                mouse.dir_left  <= (dx_p0 < 0);
                mouse.dir_up    <= (dy_p0 > 0);
                mouse.dir_down  <= (dy_p0 < 0);
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: directed packet table, randomized packets against an
// integer cursor model, and sequences for errors, timeout, resync and enable.
module tb_ps2_mouse_rx;
    import ps2_mouse_pkg::*;

    localparam int HALF = 15;
    localparam int TO   = 2000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic ps2c3 = 1'b1, ps2d3 = 1'b1, ps2c4 = 1'b1, ps2d4 = 1'b1;

    always #5 clk = ~clk;

    ps2_mouse_rx_if #(.POS_W(10)) m3 ();
    ps2_mouse_rx_if #(.POS_W(10)) m4 ();

    ps2_mouse_rx #(.PKT_BYTES(3), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .POS_W(10),
                   .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240)) dut3 (
        .clk(clk), .reset(reset), .enable(enable),
        .ps2_clk(ps2c3), .ps2_data(ps2d3), .mouse(m3));

    ps2_mouse_rx #(.PKT_BYTES(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .POS_W(10),
                   .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240)) dut4 (
        .clk(clk), .reset(reset), .enable(enable),
        .ps2_clk(ps2c4), .ps2_data(ps2d4), .mouse(m4));

    int checks = 0;
    int errors = 0;
    int pkt3 = 0, ferr3 = 0, terr3 = 0, pkt4 = 0, ferr4 = 0;

    always @(negedge clk) begin
        if (m3.pkt_valid === 1'b1)   pkt3++;
        if (m3.frame_err === 1'b1)   ferr3++;
        if (m3.timeout_err === 1'b1) terr3++;
        if (m4.pkt_valid === 1'b1)   pkt4++;
        if (m4.frame_err === 1'b1)   ferr4++;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_line(input int which, input logic c, input logic d);
        if (which == 4) begin ps2c4 = c; ps2d4 = d; end
        else            begin ps2c3 = c; ps2d3 = d; end
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) begin
            set_line(which, 1'b1, bits[i]);
            wait_clk(HALF);
            set_line(which, 1'b0, bits[i]);
            wait_clk(HALF);
        end
        set_line(which, 1'b1, 1'b1);
        wait_clk(3 * HALF);
    endtask

    task automatic send_pkt(input int which, input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_frame(which, bytes[8*i +: 8], 1'b0);
        wait_clk(10);
    endtask

    task automatic check_pkt(input string tag, input int p_before, input int btn,
                             input int dx, input int dy, input int x, input int y,
                             input int xo, input int yo, input logic [3:0] dirs);
        @(negedge clk);
        check({tag, "_pkt"},     pkt3 - p_before, 1);
        check({tag, "_buttons"}, int'(m3.buttons), btn);
        check({tag, "_dx"},      int'($signed(m3.dx)), dx);
        check({tag, "_dy"},      int'($signed(m3.dy)), dy);
        check({tag, "_x_pos"},   int'(m3.x_pos), x);
        check({tag, "_y_pos"},   int'(m3.y_pos), y);
        check({tag, "_ovf"},     int'({m3.x_ovf, m3.y_ovf}), xo * 2 + yo);
        check({tag, "_dirs"},
              int'({m3.dir_left, m3.dir_right, m3.dir_up, m3.dir_down}), int'(dirs));
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    typedef struct {
        logic [7:0] b0, b1, b2;
        int btn, dx, dy, x, y, xo, yo;
        logic [3:0] dirs;  // {left,right,up,down}
    } vec_t;

    vec_t vecs [13];

    initial begin
        int p0, f0, t0, x, y, dx, dy;
        logic [7:0] r0, r1, r2;

        vecs[0]  = '{8'h18, 8'h24, 8'hBE, 0, -220,  190, 100,  50, 0, 0, 4'b1010};
        vecs[1]  = '{8'h29, 8'h05, 8'hFE, 1,    5,   -2, 105,  52, 0, 0, 4'b0101};
        vecs[2]  = '{8'h08, 8'hFF, 8'h00, 0,  255,    0, 360,  52, 0, 0, 4'b0100};
        vecs[3]  = '{8'h08, 8'hFF, 8'h00, 0,  255,    0, 615,  52, 0, 0, 4'b0100};
        vecs[4]  = '{8'h08, 8'h16, 8'h00, 0,   22,    0, 637,  52, 0, 0, 4'b0100};
        vecs[5]  = '{8'h08, 8'h05, 8'h00, 0,    5,    0, 639,  52, 0, 0, 4'b0100};
        vecs[6]  = '{8'h18, 8'hFF, 8'h00, 0,   -1,    0, 638,  52, 0, 0, 4'b1000};
        vecs[7]  = '{8'h58, 8'hFF, 8'h00, 0,   -1,    0, 638,  52, 1, 0, 4'b1000};
        vecs[8]  = '{8'h08, 8'h00, 8'hFF, 0,    0,  255, 638,   0, 0, 0, 4'b0010};
        vecs[9]  = '{8'h2F, 8'h00, 8'h01, 7,    0, -255, 638, 255, 0, 0, 4'b0001};
        vecs[10] = '{8'h2F, 8'h00, 8'h01, 7,    0, -255, 638, 479, 0, 0, 4'b0001};
        vecs[11] = '{8'h8F, 8'h00, 8'h01, 7,    0,    1, 638, 479, 0, 1, 4'b0010};
        vecs[12] = '{8'h0C, 8'h00, 8'h00, 4,    0,    0, 638, 479, 0, 0, 4'b0000};

        // Reset state and quiet idle line.
        wait_clk(5);
        @(negedge clk);
        check("rst_x_pos", int'(m3.x_pos), 320);
        check("rst_y_pos", int'(m3.y_pos), 240);
        check("rst_fields", int'({m3.buttons, m3.dx, m3.dy, m3.dz, m3.x_ovf, m3.y_ovf}), 0);
        check("rst_dirs", int'({m3.dir_left, m3.dir_right, m3.dir_up, m3.dir_down}), 0);
        check("rst_pulses", int'({m3.pkt_valid, m3.frame_err, m3.timeout_err}), 0);
        reset = 1'b1;
        enable = 1'b1;
        wait_clk(3000);
        @(negedge clk);
        check("idle_pulses", pkt3 + ferr3 + terr3, 0);
        check("idle_x_pos", int'(m3.x_pos), 320);

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            p0 = pkt3;
            send_pkt(3, {8'h00, vecs[i].b2, vecs[i].b1, vecs[i].b0}, 3);
            check_pkt($sformatf("vec%0d", i), p0, vecs[i].btn, vecs[i].dx, vecs[i].dy,
                      vecs[i].x, vecs[i].y, vecs[i].xo, vecs[i].yo, vecs[i].dirs);
        end
        check("table_no_errs", ferr3 + terr3, 0);
        check("dz_std_zero", int'(m3.dz), 0);

        // Randomized packets against the integer model.
        x = 638;
        y = 479;
        for (int i = 0; i < 16; i++) begin
            r0 = 8'($urandom);
            r0[3] = 1'b1;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            dx = r0[4] ? int'(r1) - 256 : int'(r1);
            dy = r0[5] ? int'(r2) - 256 : int'(r2);
            if (!r0[6]) x = clampi(x + dx, 639);
            if (!r0[7]) y = clampi(y - dy, 479);
            p0 = pkt3;
            send_pkt(3, {8'h00, r2, r1, r0}, 3);
            check_pkt($sformatf("rnd%0d", i), p0, int'(r0[2:0]), dx, dy, x, y,
                      int'(r0[6]), int'(r0[7]),
                      {dx < 0, dx > 0, dy > 0, dy < 0});
        end

        // Bad parity alone, then bad parity mid-packet, then a good packet.
        p0 = pkt3; f0 = ferr3;
        send_frame(3, 8'h08, 1'b1);
        wait_clk(10);
        check("parity_ferr", int'(ferr3 > f0), 1);
        check("parity_no_pkt", pkt3 - p0, 0);
        f0 = ferr3;
        send_frame(3, 8'h08, 1'b0);
        send_frame(3, 8'h07, 1'b1);
        wait_clk(10);
        check("parity_mid_ferr", int'(ferr3 > f0), 1);
        p0 = pkt3;
        send_pkt(3, 32'h0000_0408, 3);
        @(negedge clk);
        check("after_perr_pkt", pkt3 - p0, 1);
        check("after_perr_dx", int'($signed(m3.dx)), 4);

        // Partial packet aborted by the watchdog.
        p0 = pkt3; t0 = terr3;
        send_frame(3, 8'h08, 1'b0);
        send_frame(3, 8'h05, 1'b0);
        wait_clk(TO + 300);
        check("timeout_pulse", terr3 - t0, 1);
        check("timeout_no_pkt", pkt3 - p0, 0);
        send_pkt(3, 32'h0000_0208, 3);
        @(negedge clk);
        check("after_to_pkt", pkt3 - p0, 1);
        check("after_to_dx", int'($signed(m3.dx)), 2);

        // Leading byte without the sync bit is silently dropped.
        p0 = pkt3; f0 = ferr3;
        send_frame(3, 8'h00, 1'b0);
        send_pkt(3, 32'h0000_0308, 3);
        @(negedge clk);
        check("resync_pkt", pkt3 - p0, 1);
        check("resync_no_ferr", ferr3 - f0, 0);
        check("resync_dx", int'($signed(m3.dx)), 3);

        // enable=0 drops a partial packet and ignores traffic.
        p0 = pkt3;
        send_frame(3, 8'h08, 1'b0);
        enable = 1'b0;
        wait_clk(5);
        x = int'(m3.x_pos);
        send_pkt(3, 32'h0000_0908, 3);
        @(negedge clk);
        check("dis_no_pkt", pkt3 - p0, 0);
        check("dis_x_hold", int'(m3.x_pos), x);
        enable = 1'b1;
        wait_clk(5);
        send_pkt(3, 32'h0000_0108, 3);
        @(negedge clk);
        check("en_pkt", pkt3 - p0, 1);
        check("en_dx", int'($signed(m3.dx)), 1);

        // Wheel variant.
        send_pkt(4, 32'h0F00_0008, 4);
        @(negedge clk);
        check("wheel_pkt", pkt4, 1);
        check("wheel_dz", int'($signed(m4.dz)), -1);
        check("wheel_ferr", ferr4, 0);
        send_pkt(4, 32'h0000_0108, 3);
        wait_clk(200);
        @(negedge clk);
        check("wheel_3byte_no_pkt", pkt4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
